// File: rtl/calc_button_pkg.sv
// Shared definitions for the calculator button bus: 10-bit button codes,
// the keypad encoder state encoding and the keypad index to code mapping.
package calc_button_pkg;

    localparam logic [9:0] BTN_D0    = 10'b00_0000_0001;
    localparam logic [9:0] BTN_D1    = 10'b00_0000_0010;
    localparam logic [9:0] BTN_D2    = 10'b00_0000_0100;
    localparam logic [9:0] BTN_D3    = 10'b00_0000_1000;
    localparam logic [9:0] BTN_D4    = 10'b00_0001_0000;
    localparam logic [9:0] BTN_D5    = 10'b00_0010_0000;
    localparam logic [9:0] BTN_D6    = 10'b00_0100_0000;
    localparam logic [9:0] BTN_D7    = 10'b00_1000_0000;
    localparam logic [9:0] BTN_D8    = 10'b01_0000_0000;
    localparam logic [9:0] BTN_D9    = 10'b01_0000_0001;
    localparam logic [9:0] BTN_ADD   = 10'b10_0000_0001;
    localparam logic [9:0] BTN_SUB   = 10'b10_0000_0010;
    localparam logic [9:0] BTN_MUL   = 10'b10_0000_0100;
    localparam logic [9:0] BTN_DIV   = 10'b10_0000_1000;
    localparam logic [9:0] BTN_EQUAL = 10'b11_0000_0000;
    localparam logic [9:0] BTN_CLEAR = 10'b11_1000_0000;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } kp_state_e;

    // Keypad index is row*4+col; layout is
    //   1 2 3 ADD / 4 5 6 SUB / 7 8 9 MUL / CLEAR 0 EQUAL DIV
    function automatic logic [9:0] key_code(input logic [3:0] idx);
        logic [9:0] code;
        code = '0;
        case (idx)
            4'd0:  code = BTN_D1;
            4'd1:  code = BTN_D2;
            4'd2:  code = BTN_D3;
            4'd3:  code = BTN_ADD;
            4'd4:  code = BTN_D4;
            4'd5:  code = BTN_D5;
            4'd6:  code = BTN_D6;
            4'd7:  code = BTN_SUB;
            4'd8:  code = BTN_D7;
            4'd9:  code = BTN_D8;
            4'd10: code = BTN_D9;
            4'd11: code = BTN_MUL;
            4'd12: code = BTN_CLEAR;
            4'd13: code = BTN_D0;
            4'd14: code = BTN_EQUAL;
            4'd15: code = BTN_DIV;
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 active-low keypad: synchronises the rows, drives
// one column low at a time and assembles a 16-bit pressed-key frame, strobing
// frame_done for one cycle when a full frame is available.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] frame,
    output logic        frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      snap_q, snap_d;
    logic [15:0]      frame_q, frame_d;
    logic             frame_done_q, frame_done_d;
    logic             last_div;

    // Divider, column advance and per-column row capture into the snapshot
    always_comb begin
        last_div     = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d        = last_div ? '0 : div_q + 1'b1;
        col_d        = last_div ? col_q + 2'd1 : col_q;
        snap_d       = snap_q;
        frame_d      = frame_q;
        frame_done_d = 1'b0;
        if (last_div) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[r*4 + int'(col_q)] = ~row_sync_q[r];
            end
            if (col_q == 2'd3) begin
                frame_d      = snap_d;
                frame_done_d = 1'b1;
            end
        end
    end

    // Two-flop row synchroniser plus scan state; idle rows read as released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            div_q        <= '0;
            col_q        <= 2'd0;
            snap_q       <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_meta_q   <= row_in;
            row_sync_q   <= row_meta_q;
            div_q        <= div_d;
            col_q        <= col_d;
            snap_q       <= snap_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col_out    = ~(4'b0001 << col_q);
    assign frame      = frame_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/keypad_button_encoder.sv
// Keypad front end for the calculator: debounces single key presses from the
// scanner frames and emits one registered button code pulse per accepted
// press, then holds busy until a clean release has been seen.
module keypad_button_encoder
    import calc_button_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [9:0] button,
    output logic       key_valid,
    output logic       busy
);

    localparam logic [7:0] DB_LIM = 8'(DEBOUNCE_CNT);

    logic [15:0] frame;
    logic        frame_done;
    logic        frame_single;
    logic [3:0]  frame_idx;

    kp_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic [9:0]  button_q, button_d;
    logic        key_valid_q, key_valid_d;
    logic        busy_q, busy_d;
    logic        accept;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_out    (col_out),
        .frame      (frame),
        .frame_done (frame_done)
    );

    // Classify the frame: exactly one key down, and which one
    always_comb begin
        frame_single = (frame != 16'd0) && ((frame & (frame - 16'd1)) == 16'd0);
        frame_idx    = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) frame_idx = 4'(i);
        end
    end

    // Press/release debounce; a press is accepted straight into the one-cycle EMIT
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        button_d    = '0;
        key_valid_d = 1'b0;
        busy_d      = busy_q;
        accept      = 1'b0;
        case (state_q)
            SCAN: begin
                if (frame_done && frame_single) begin
                    key_d = frame_idx;
                    if (DB_LIM == 8'd1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = DEBOUNCE;
                        cnt_d   = 8'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (frame_done) begin
                    if (frame == (16'd1 << key_q)) begin
                        if (cnt_q + 8'd1 == DB_LIM) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
            end
            EMIT: begin
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (frame_done) begin
                    if (frame == 16'd0) begin
                        if (cnt_q + 8'd1 == DB_LIM) begin
                            state_d = SCAN;
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
        if (accept) begin
            state_d     = EMIT;
            cnt_d       = '0;
            button_d    = key_code(key_d);
            key_valid_d = 1'b1;
            busy_d      = 1'b1;
        end
    end

    // State and registered outputs; reset drops any press in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            key_q       <= '0;
            button_q    <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            button_q    <= button_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign button    = button_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule
